instr_issuer: RTL

- Initiator side of the processor's Run/Done instruction handshake.
- A host loads 9-bit instruction words, and any mvi immediate words, into an internal program FIFO.
- The block presents each instruction on DIN with a single-cycle Run pulse, then holds the mvi immediate on DIN until Done.
- It waits for Done before issuing the next instruction, and counts completed instructions.
- Sits between the testbench/host loader and the controller/datapath top level.

---
 rtl/instr_issuer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/instr_issuer.sv
// instr_issuer: program FIFO feeding the processor's Run/Done handshake, one instruction at a time.
// Optional Done watchdog is compiled in when ISSUER_TIMEOUT_EN is defined.

module instr_issuer #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int TMO   = 15
) (
   input  logic       Clock,
   input  logic       Resetn,
   input  logic       wr_en,
   input  logic [8:0] wr_data,
   output logic       full,
   input  logic       start,
   output logic [8:0] DIN,
   output logic       Run,
   input  logic       Done,
   output logic       busy,
   output logic [7:0] instr_count,
   output logic       bad_op,
   output logic       err_timeout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_IMM   = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   localparam logic [2:0]  OP_MVI   = 3'b011;
   localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0] CNT_TWO  = (AW + 1)'(2);

   if (DEPTH != (1 << AW) || TMO < 2) begin : g_param_chk
      $error("instr_issuer: DEPTH must equal 2**AW and TMO must be at least 2");
   end

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic [1:0]    state;
   logic          armed;
   logic [8:0]    head;
   logic          wr_ok;
   logic          drop;
   logic          issue;
   logic          pop;

   assign head  = mem[rptr];
   assign full  = (count == CNT_FULL);
   assign wr_ok = wr_en && !full;

   // An mvi only leaves IDLE once its immediate is already queued behind it.
   always_comb begin
      drop  = 1'b0;
      issue = 1'b0;
      if (state == S_IDLE && armed && count != '0) begin
         if (head[8])
            drop = 1'b1;
         else if (!(head[8:6] == OP_MVI && count < CNT_TWO))
            issue = 1'b1;
      end
   end

   // In ISSUE, DIN still holds the instruction, so its opcode decides the immediate pop.
   assign pop = drop | issue | (state == S_ISSUE && DIN[8:6] == OP_MVI);

   always_ff @(posedge Clock) begin
      if (wr_ok)
         mem[wptr] <= wr_data;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (wr_ok)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         count <= count + (AW + 1)'(wr_ok) - (AW + 1)'(pop);
      end
   end

`ifdef ISSUER_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0] tmo_cnt;
   logic          timeout;

   // tmo_cnt equals the number of cycles elapsed since the Run cycle.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         tmo_cnt <= '0;
      else if (state == S_IDLE)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   assign timeout = ((state == S_IMM) || (state == S_WAIT && !Done)) &&
                    (tmo_cnt == CW'(TMO - 1));
`else
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state       <= S_IDLE;
         armed       <= 1'b0;
         DIN         <= '0;
         Run         <= 1'b0;
         busy        <= 1'b0;
         instr_count <= '0;
         bad_op      <= 1'b0;
`ifdef ISSUER_TIMEOUT_EN
         err_timeout <= 1'b0;
`endif
      end else begin
         Run <= 1'b0;
         if (start)
            armed <= 1'b1;
         else if (state == S_IDLE && count == '0)
            armed <= 1'b0;

         case (state)
            S_IDLE: begin
               if (drop)
                  bad_op <= 1'b1;
               if (issue) begin
                  DIN   <= head;
                  Run   <= 1'b1;
                  busy  <= 1'b1;
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (DIN[8:6] == OP_MVI) begin
                  DIN   <= head;
                  state <= S_IMM;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_IMM:
               state <= S_WAIT;
            default: begin
               if (Done) begin
                  instr_count <= instr_count + 1'b1;
                  busy        <= 1'b0;
                  state       <= S_IDLE;
               end
            end
         endcase

`ifdef ISSUER_TIMEOUT_EN
         if (timeout) begin
            err_timeout <= 1'b1;
            busy        <= 1'b0;
            armed       <= 1'b0;
            state       <= S_IDLE;
         end
`endif
      end
   end

endmodule
